// File: rtl/dmem_responder.sv
// Load/store responder for the core data port: one outstanding request, byte-lane
// RAM with registered read, configurable load latency and an error response path.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LATENCY  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW          = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);
   // WAIT lasts RD_LATENCY-1 cycles; the counter exits WAIT when it reads zero
   localparam logic [1:0]  WAIT_INIT   = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    cnt_reg;
   logic          err_reg;
   logic          rd_sel_reg;
   logic [1:0]    lane_reg;
   logic [1:0]    size_reg;
   logic          uns_reg;

   logic          accept, req_err, wr_en, rd_en;
   logic [AW-1:0] word_idx;
   logic [3:0]    lane_en;
   logic [31:0]   wr_data;
   logic [31:0]   rd_word;
   logic [31:0]   shifted;
   logic [31:0]   ext_data;

   assign word_idx = req_addr[AW+1:2];
   assign req_err  = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                   || ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);
   assign accept   = (state_reg == IDLE) && req_valid;
   assign wr_en    = accept && req_we && !req_err;
   assign rd_en    = accept && !req_we && !req_err;

   // Store data is replicated across lanes so each lane just picks its own byte
   always_comb begin
      lane_en = 4'b0000;
      wr_data = req_wdata;
      case (req_size)
         2'd0: begin
            lane_en = 4'b0001 << req_addr[1:0];
            wr_data = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            lane_en = req_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata[15:0]}};
         end
         2'd2: lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] rd_byte_reg;

         always_ff @(posedge clk) begin
            if (wr_en && lane_en[gi])
               lane_mem[word_idx] <= wr_data[gi*8 +: 8];
            if (rd_en)
               rd_byte_reg <= lane_mem[word_idx];
         end

         assign rd_word[gi*8 +: 8] = rd_byte_reg;
      end
   endgenerate

   always_comb begin
      shifted  = rd_word >> {lane_reg, 3'b000};
      ext_data = shifted;
      case (size_reg)
         2'd0:    ext_data = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
         2'd1:    ext_data = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
         default: ext_data = shifted;
      endcase
      rsp_rdata = rd_sel_reg ? ext_data : 32'd0;
   end

   assign rsp_err = err_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err || req_we || (RD_LATENCY == 1))
                  state_next = RESP;
               else
                  state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg == 2'd0)
               state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Response attributes are captured at acceptance and held until the next one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg    <= 2'd0;
         err_reg    <= 1'b0;
         rd_sel_reg <= 1'b0;
         lane_reg   <= 2'd0;
         size_reg   <= 2'd0;
         uns_reg    <= 1'b0;
      end else if (accept) begin
         cnt_reg    <= WAIT_INIT;
         err_reg    <= req_err;
         rd_sel_reg <= rd_en;
         lane_reg   <= req_addr[1:0];
         size_reg   <= req_size;
         uns_reg    <= req_unsigned;
      end else if ((state_reg == WAIT) && (cnt_reg != 2'd0)) begin
         cnt_reg    <= cnt_reg - 2'd1;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level memory model predicts every
// response, and each task covers one scenario of the load/store port.
module tb_dmem_responder;

   localparam int RDL   = 2;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mdl [4*DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(RDL)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'd3) return 1'b1;
      if (s == 2'd1 && a[0]) return 1'b1;
      if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
      if (a >= 32'(4 * DEPTH)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
      logic [7:0]  b;
      logic [15:0] h;
      int          i;
      i = int'(a[11:0]);
      case (s)
         2'd0: begin
            b = mdl[i];
            return u ? {24'd0, b} : {{24{b[7]}}, b};
         end
         2'd1: begin
            h = {mdl[i+1], mdl[i]};
            return u ? {16'd0, h} : {{16{h[15]}}, h};
         end
         default: return {mdl[i+3], mdl[i+2], mdl[i+1], mdl[i]};
      endcase
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
      int i;
      i = int'(a[11:0]);
      mdl[i] = w[7:0];
      if (s != 2'd0) mdl[i+1] = w[15:8];
      if (s == 2'd2) begin
         mdl[i+2] = w[23:16];
         mdl[i+3] = w[31:24];
      end
   endtask

   // Called right after a falling edge; the request is accepted on the next rising edge
   task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] w);
      exp_t e;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL issue_ready addr=%h got req_ready=%b want 1", a, req_ready);
      end
      e.addr  = a;
      e.we    = we;
      e.err   = model_err(a, s);
      e.rdata = (we || e.err) ? 32'd0 : model_load(a, s, u);
      e.lat   = (we || e.err) ? 1 : RDL;
      if (we && !e.err) model_store(a, s, w);
      sb.push_back(e);
      req_valid = 1'b1; req_we = we; req_addr = a; req_size = s;
      req_unsigned = u; req_wdata = w;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic collect();
      exp_t e;
      int   n;
      e = sb.pop_front();
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!rsp_valid) begin
            total++;
            if (req_ready !== 1'b0) begin
               bad++;
               $display("FAIL busy_ready addr=%h got req_ready=%b want 0", e.addr, req_ready);
            end
         end
      end while (!rsp_valid && n < 16);
      total++;
      if (rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL rsp_timeout addr=%h got no rsp_valid want one within 16 cycles", e.addr);
         return;
      end
      $display("txn we=%0b addr=%h rdata=%h err=%0b lat=%0d", e.we, e.addr, rsp_rdata, rsp_err, n);
      total++;
      if (n !== e.lat) begin
         bad++;
         $display("FAIL latency addr=%h got %0d want %0d", e.addr, n, e.lat);
      end
      total++;
      if (rsp_rdata !== e.rdata) begin
         bad++;
         $display("FAIL rdata addr=%h got %h want %h", e.addr, rsp_rdata, e.rdata);
      end
      total++;
      if (rsp_err !== e.err) begin
         bad++;
         $display("FAIL err addr=%h got %b want %b", e.addr, rsp_err, e.err);
      end
   endtask

   task automatic handshake_check();
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL handshake got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] w);
      issue(we, a, s, u, w);
      collect();
      handshake_check();
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
      req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_state got ready=%b valid=%b err=%b rdata=%h want 1/0/0/0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_store_load();
      txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
      txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
   endtask

   task automatic test_byte_ext();
      txn(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080);
      txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
      txn(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
      txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      txn(1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
      txn(1'b0, 32'h10, 2'd1, 1'b1, 32'h0);
   endtask

   task automatic test_errors();
      txn(1'b0, 32'h11, 2'd1, 1'b0, 32'h0);
      txn(1'b1, 32'h12, 2'd2, 1'b0, 32'h1234_5678);
      txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      txn(1'b1, 32'h20, 2'd3, 1'b0, 32'hFFFF_FFFF);
      txn(1'b0, 32'h20, 2'd3, 1'b0, 32'h0);
   endtask

   task automatic test_range();
      txn(1'b1, 32'hFFC, 2'd2, 1'b0, 32'h1234_5678);
      txn(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0);
      txn(1'b1, 32'h1000, 2'd0, 1'b0, 32'hAA);
      txn(1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0);
      txn(1'b0, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'h0);
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      collect();
      held = rsp_rdata;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL backpressure cyc=%0d got valid=%b rdata=%h ready=%b want 1/%h/0",
                     i, rsp_valid, rsp_rdata, req_ready, held);
         end
      end
      rsp_ready = 1'b1;
      handshake_check();
   endtask

   task automatic test_reset_midload();
      // Store whose response is cut short by reset must still be in RAM
      issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      void'(sb.pop_front());
      issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_wait got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_reset cyc=%0d got valid=%b ready=%b want 0/1", i, rsp_valid, req_ready);
         end
      end
      txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      txn(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++)
         txn(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom);
      for (int i = 0; i < 24; i++)
         txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_ext();
      test_errors();
      test_range();
      test_backpressure();
      test_reset_midload();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
